block_interleaver_pp: RTL

Parametrised ping-pong block interleaver/deinterleaver for the 32-bit transmit/receive streaming path, sitting between frame sync and the DDR4 interleaver stage.
- Stores one block of ROWS×COLS words per bank while the other bank is streamed out.
- Runtime mode selects interleave (column-write / row-read) or the exact inverse (row-write / column-read), so one block serves both TX and RX.
- Sustains one word per clock in and out, with full AXIS backpressure and frame-boundary `tlast` checking and generation.

---
 rtl/block_interleaver_pp.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/block_interleaver_pp.sv
// block_interleaver_pp: ping-pong ROWSxCOLS block interleaver / deinterleaver.
// One bank of the shared memory fills while the other streams out. The mode is
// latched per bank, so the read side always undoes exactly what its writer did.
module block_interleaver_pp #(
  parameter int DATA_W = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 70
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              frame_err
);

  localparam int N  = ROWS * COLS;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int AW = $clog2(2 * N);

  localparam logic [KW-1:0] K_LAST   = KW'(N - 1);
  localparam logic [RW-1:0] R_LAST   = RW'(ROWS - 1);
  localparam logic [AW-1:0] BANK_OFS = AW'(N);
  localparam logic [AW-1:0] COLS_A   = AW'(COLS);

  logic [DATA_W-1:0] mem [0:2*N-1];

  // write side: word counter plus running row/column split of it
  logic [KW-1:0] wr_k;
  logic [RW-1:0] wr_r;
  logic [CW-1:0] wr_c;
  logic          wr_bank;
  logic          wr_accept;
  logic          wr_last;
  logic [AW-1:0] wr_addr;

  // read side: same counter structure as the write side
  logic [KW-1:0] rd_m;
  logic [RW-1:0] rd_r;
  logic [CW-1:0] rd_c;
  logic          rd_bank;
  logic          rd_issue;
  logic          rd_last;
  logic [AW-1:0] rd_addr;

  // per-bank state
  logic [1:0] full;
  logic [1:0] full_next;
  logic [1:0] bank_mode;
  logic       wr_bank_next;

  // 2-entry output buffer
  logic [DATA_W-1:0] out_data [2];
  logic [1:0]        out_last;
  logic              out_wr_ptr;
  logic              out_rd_ptr;
  logic [1:0]        out_count;
  logic              pop;

  function automatic logic [AW-1:0] rc_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * COLS_A + AW'(c);
  endfunction

  // Address generation, handshakes and next-state bank flags. At k=0 both
  // address forms are 0, so the not-yet-latched mode bit cannot matter there.
  always_comb begin
    wr_accept    = s_axis_tvalid & s_axis_tready;
    wr_last      = (wr_k == K_LAST);
    wr_addr      = (wr_bank ? BANK_OFS : '0) +
                   (bank_mode[wr_bank] ? AW'(wr_k) : rc_addr(wr_r, wr_c));
    pop          = m_axis_tvalid & m_axis_tready;
    rd_last      = (rd_m == K_LAST);
    rd_issue     = full[rd_bank] & ((out_count != 2'd2) | pop);
    rd_addr      = (rd_bank ? BANK_OFS : '0) +
                   (bank_mode[rd_bank] ? rc_addr(rd_r, rd_c) : AW'(rd_m));
    full_next    = full;
    if (wr_accept && wr_last) full_next[wr_bank] = 1'b1;
    if (rd_issue && rd_last)  full_next[rd_bank] = 1'b0;
    wr_bank_next = wr_bank ^ (wr_accept & wr_last);
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_addr] <= s_axis_tdata;
  end

  // Write counters, bank toggle, per-bank mode latch and tlast check.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_k      <= '0;
      wr_r      <= '0;
      wr_c      <= '0;
      wr_bank   <= 1'b0;
      bank_mode <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= wr_accept & (s_axis_tlast != wr_last);
      if (wr_accept) begin
        if (wr_k == '0) bank_mode[wr_bank] <= mode;
        if (wr_last) begin
          wr_k    <= '0;
          wr_r    <= '0;
          wr_c    <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_k <= wr_k + 1'b1;
          if (wr_r == R_LAST) begin
            wr_r <= '0;
            wr_c <= wr_c + 1'b1;
          end else begin
            wr_r <= wr_r + 1'b1;
          end
        end
      end
    end
  end

  // Read counters and read bank toggle, advanced on every issued read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_m    <= '0;
      rd_r    <= '0;
      rd_c    <= '0;
      rd_bank <= 1'b0;
    end else if (rd_issue) begin
      if (rd_last) begin
        rd_m    <= '0;
        rd_r    <= '0;
        rd_c    <= '0;
        rd_bank <= ~rd_bank;
      end else begin
        rd_m <= rd_m + 1'b1;
        if (rd_r == R_LAST) begin
          rd_r <= '0;
          rd_c <= rd_c + 1'b1;
        end else begin
          rd_r <= rd_r + 1'b1;
        end
      end
    end
  end

  // Bank full flags and registered input ready, looking at next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      full          <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      full          <= full_next;
      s_axis_tready <= ~full_next[wr_bank_next];
    end
  end

  // Registered memory read lands directly in the output buffer with its tlast.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data[0] <= '0;
      out_data[1] <= '0;
      out_last    <= '0;
      out_wr_ptr  <= 1'b0;
      out_rd_ptr  <= 1'b0;
      out_count   <= '0;
    end else begin
      if (rd_issue) begin
        out_data[out_wr_ptr] <= mem[rd_addr];
        out_last[out_wr_ptr] <= rd_last;
        out_wr_ptr           <= ~out_wr_ptr;
      end
      if (pop) out_rd_ptr <= ~out_rd_ptr;
      out_count <= out_count + {1'b0, rd_issue} - {1'b0, pop};
    end
  end

  assign m_axis_tvalid = (out_count != 2'd0);
  assign m_axis_tdata  = out_data[out_rd_ptr];
  assign m_axis_tlast  = out_last[out_rd_ptr];

endmodule
